tluh_wide_to_narrow_bridge: RTL and testbench

//  Downstream adapter from the 128-bit wide TL-UH fabric (tluh_wide structs) to a 32-bit TL-UH peripheral port.

---
 rtl/tluh_wide_to_narrow_bridge.sv | 390 +++++++++++++++++++++++++++++++++++++++
 tb/tb_tluh_wide_to_narrow_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tluh_wide_to_narrow_bridge.sv
// Wide (128-bit) to narrow (32-bit) TL-UH downstream bridge.
// Splits one wide single-beat request into a narrow burst, gathers the
// narrow D beats back into a single wide D beat. One transaction in flight.

package wide_tilelink_defines;
    localparam int unsigned TL_AW   = 28;   // address width
    localparam int unsigned TL_DW   = 128;  // wide data width
    localparam int unsigned TL_DBW  = 16;   // wide byte-mask width
    localparam int unsigned TL_SZW  = 3;    // size field width
    localparam int unsigned TL_AIW  = 2;    // source id width
    localparam int unsigned TL_DIW  = 1;    // sink id width
endpackage

package tluh_wide;
    import wide_tilelink_defines::*;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITH       = 3'd2;
    localparam logic [2:0] A_LOGICAL     = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_INTENT      = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;
    localparam logic [2:0] D_HINT_ACK    = 3'd2;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                a_corrupt;
        logic                d_ready;
    } tluh_m2s;

    typedef struct packed {
        logic                a_ready;
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [1:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic                d_denied;
        logic [TL_DW-1:0]    d_data;
        logic                d_corrupt;
    } tluh_s2m;
endpackage

module tluh_wide_to_narrow_bridge #(
    parameter int unsigned NDW    = 32,
    parameter int unsigned NSINKW = wide_tilelink_defines::TL_DIW
) (
    input  logic                 tilelink_clock_i,
    input  logic                 tilelink_reset_ni,
    input  tluh_wide::tluh_m2s   w_m2s_i,
    output tluh_wide::tluh_s2m   w_s2m_o,
    output logic [2:0]           n_a_opcode_o,
    output logic [2:0]           n_a_param_o,
    output logic [2:0]           n_a_size_o,
    output logic [1:0]           n_a_source_o,
    output logic [27:0]          n_a_address_o,
    output logic [NDW/8-1:0]     n_a_mask_o,
    output logic [NDW-1:0]       n_a_data_o,
    output logic                 n_a_corrupt_o,
    output logic                 n_a_valid_o,
    input  logic                 n_a_ready_i,
    input  logic [2:0]           n_d_opcode_i,
    input  logic [1:0]           n_d_param_i,
    input  logic [2:0]           n_d_size_i,
    input  logic [1:0]           n_d_source_i,
    input  logic [NSINKW-1:0]    n_d_sink_i,
    input  logic                 n_d_denied_i,
    input  logic [NDW-1:0]       n_d_data_i,
    input  logic                 n_d_corrupt_i,
    input  logic                 n_d_valid_i,
    output logic                 n_d_ready_o
);
    import tluh_wide::*;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        COLLECT = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e        state_q, state_d;

    // captured request
    logic [2:0]    opcode_q,  opcode_d;
    logic [2:0]    param_q,   param_d;
    logic [2:0]    size_q,    size_d;
    logic [1:0]    source_q,  source_d;
    logic [27:0]   address_q, address_d;
    logic [15:0]   mask_q,    mask_d;
    logic [127:0]  data_q,    data_d;
    logic          corrupt_q, corrupt_d;

    // burst bookkeeping
    logic [1:0]    start_lane_q, start_lane_d;
    logic [2:0]    nbeats_q,     nbeats_d;
    logic [2:0]    abeats_q,     abeats_d;
    logic [2:0]    acnt_q,       acnt_d;
    logic [2:0]    dcnt_q,       dcnt_d;
    logic          a_started_q,  a_started_d;
    logic          d_done_q,     d_done_d;

    // response accumulation
    logic [2:0]    rsp_opcode_q,  rsp_opcode_d;
    logic [1:0]    rsp_param_q,   rsp_param_d;
    logic [NSINKW-1:0] rsp_sink_q, rsp_sink_d;
    logic          rsp_denied_q,  rsp_denied_d;
    logic          rsp_corrupt_q, rsp_corrupt_d;
    logic [127:0]  rsp_data_q,    rsp_data_d;

    // request decode
    logic [2:0]    req_nbeats;
    logic [1:0]    req_lane;
    logic          req_unsupported;
    logic          req_single_a;
    logic [2:0]    req_err_opcode;

    // handshake helpers
    logic          a_rdy;
    logic          d_rdy;
    logic          a_fire;
    logic          a_last;
    logic          d_fire;
    logic          d_last;
    logic [1:0]    a_lane;
    logic [1:0]    d_lane;
    logic [2:0]    first_d_op;
    logic [2:0]    d_expect;

    // D size/source are implied by the single outstanding request
    logic          unused_d_fields;
    assign unused_d_fields = ^{n_d_size_i, n_d_source_i};

    // Decode beat count, start lane and error opcode of the incoming request
    always_comb begin
        req_nbeats      = 3'd1;
        req_lane        = w_m2s_i.a_address[3:2];
        req_unsupported = 1'b0;
        case (w_m2s_i.a_size)
            3'd0, 3'd1, 3'd2: begin
                req_nbeats = 3'd1;
                req_lane   = w_m2s_i.a_address[3:2];
            end
            3'd3: begin
                req_nbeats = 3'd2;
                req_lane   = {w_m2s_i.a_address[3], 1'b0};
            end
            3'd4: begin
                req_nbeats = 3'd4;
                req_lane   = 2'd0;
            end
            default: begin
                req_nbeats      = 3'd1;
                req_lane        = 2'd0;
                req_unsupported = 1'b1;
            end
        endcase
        req_single_a = (w_m2s_i.a_opcode == A_GET) || (w_m2s_i.a_opcode == A_INTENT);
        case (w_m2s_i.a_opcode)
            A_GET, A_ARITH, A_LOGICAL: req_err_opcode = D_ACK_DATA;
            A_INTENT:                  req_err_opcode = D_HINT_ACK;
            default:                   req_err_opcode = D_ACK;
        endcase
    end

    // Next-state, burst counters and response accumulation
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        param_d       = param_q;
        size_d        = size_q;
        source_d      = source_q;
        address_d     = address_q;
        mask_d        = mask_q;
        data_d        = data_q;
        corrupt_d     = corrupt_q;
        start_lane_d  = start_lane_q;
        nbeats_d      = nbeats_q;
        abeats_d      = abeats_q;
        acnt_d        = acnt_q;
        dcnt_d        = dcnt_q;
        a_started_d   = a_started_q;
        d_done_d      = d_done_q;
        rsp_opcode_d  = rsp_opcode_q;
        rsp_param_d   = rsp_param_q;
        rsp_sink_d    = rsp_sink_q;
        rsp_denied_d  = rsp_denied_q;
        rsp_corrupt_d = rsp_corrupt_q;
        rsp_data_d    = rsp_data_q;

        a_rdy  = 1'b0;
        d_rdy  = 1'b0;
        a_fire = 1'b0;
        a_last = 1'b0;
        d_fire = 1'b0;
        d_last = 1'b0;
        a_lane = start_lane_q + acnt_q[1:0];
        d_lane = start_lane_q + dcnt_q[1:0];

        // The first D beat decides how many beats follow
        first_d_op = (dcnt_q == 3'd0) ? n_d_opcode_i : rsp_opcode_q;
        d_expect   = (first_d_op == D_ACK_DATA) ? nbeats_q : 3'd1;

        case (state_q)
            IDLE: begin
                a_rdy = tilelink_reset_ni;
                if (w_m2s_i.a_valid) begin
                    opcode_d      = w_m2s_i.a_opcode;
                    param_d       = w_m2s_i.a_param;
                    size_d        = w_m2s_i.a_size;
                    source_d      = w_m2s_i.a_source;
                    address_d     = w_m2s_i.a_address;
                    mask_d        = w_m2s_i.a_mask;
                    data_d        = w_m2s_i.a_data;
                    corrupt_d     = w_m2s_i.a_corrupt;
                    start_lane_d  = req_lane;
                    nbeats_d      = req_nbeats;
                    abeats_d      = req_single_a ? 3'd1 : req_nbeats;
                    acnt_d        = '0;
                    dcnt_d        = '0;
                    a_started_d   = 1'b0;
                    d_done_d      = 1'b0;
                    rsp_param_d   = '0;
                    rsp_sink_d    = '0;
                    rsp_data_d    = '0;
                    if (req_unsupported) begin
                        rsp_opcode_d  = req_err_opcode;
                        rsp_denied_d  = 1'b1;
                        rsp_corrupt_d = (req_err_opcode == D_ACK_DATA);
                        state_d       = RESP;
                    end else begin
                        rsp_opcode_d  = '0;
                        rsp_denied_d  = 1'b0;
                        rsp_corrupt_d = 1'b0;
                        state_d       = SEND;
                    end
                end
            end
            SEND: begin
                d_rdy  = a_started_q & ~d_done_q;
                a_fire = n_a_ready_i;
                a_last = a_fire && ((acnt_q + 3'd1) == abeats_q);
            end
            COLLECT: begin
                d_rdy = ~d_done_q;
            end
            RESP: begin
                if (w_m2s_i.d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (a_fire) begin
            acnt_d      = acnt_q + 3'd1;
            a_started_d = 1'b1;
        end

        d_fire = d_rdy & n_d_valid_i;
        if (d_fire) begin
            rsp_data_d[{d_lane, 5'd0} +: 32] = n_d_data_i;
            rsp_denied_d  = rsp_denied_q  | n_d_denied_i;
            rsp_corrupt_d = rsp_corrupt_q | n_d_corrupt_i;
            if (dcnt_q == 3'd0) begin
                rsp_opcode_d = n_d_opcode_i;
                rsp_param_d  = n_d_param_i;
                rsp_sink_d   = n_d_sink_i;
            end
            dcnt_d = dcnt_q + 3'd1;
            d_last = ((dcnt_q + 3'd1) == d_expect);
            if (d_last) begin
                d_done_d = 1'b1;
            end
        end

        // A and D completion may land in either order or in the same cycle
        if ((state_q == SEND) && a_last) begin
            state_d = (d_done_q || d_last) ? RESP : COLLECT;
        end
        if ((state_q == COLLECT) && d_last) begin
            state_d = RESP;
        end
    end

    // Drive narrow A, narrow D ready and the wide response from registered state
    always_comb begin
        n_a_opcode_o  = '0;
        n_a_param_o   = '0;
        n_a_size_o    = '0;
        n_a_source_o  = '0;
        n_a_address_o = '0;
        n_a_mask_o    = '0;
        n_a_data_o    = '0;
        n_a_corrupt_o = 1'b0;
        n_a_valid_o   = 1'b0;
        n_d_ready_o   = d_rdy;
        w_s2m_o       = '0;
        w_s2m_o.a_ready = a_rdy;

        if (state_q == SEND) begin
            n_a_valid_o   = 1'b1;
            n_a_opcode_o  = opcode_q;
            n_a_param_o   = param_q;
            n_a_size_o    = size_q;
            n_a_source_o  = source_q;
            n_a_address_o = address_q;
            n_a_mask_o    = mask_q[{a_lane, 2'd0} +: 4];
            n_a_data_o    = data_q[{a_lane, 5'd0} +: 32];
            n_a_corrupt_o = corrupt_q;
        end

        if (state_q == RESP) begin
            w_s2m_o.d_valid   = 1'b1;
            w_s2m_o.d_opcode  = rsp_opcode_q;
            w_s2m_o.d_param   = rsp_param_q;
            w_s2m_o.d_size    = size_q;
            w_s2m_o.d_source  = source_q;
            w_s2m_o.d_sink    = rsp_sink_q;
            w_s2m_o.d_denied  = rsp_denied_q;
            w_s2m_o.d_data    = rsp_data_q;
            w_s2m_o.d_corrupt = rsp_corrupt_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            state_q       <= IDLE;
            opcode_q      <= '0;
            param_q       <= '0;
            size_q        <= '0;
            source_q      <= '0;
            address_q     <= '0;
            mask_q        <= '0;
            data_q        <= '0;
            corrupt_q     <= 1'b0;
            start_lane_q  <= '0;
            nbeats_q      <= '0;
            abeats_q      <= '0;
            acnt_q        <= '0;
            dcnt_q        <= '0;
            a_started_q   <= 1'b0;
            d_done_q      <= 1'b0;
            rsp_opcode_q  <= '0;
            rsp_param_q   <= '0;
            rsp_sink_q    <= '0;
            rsp_denied_q  <= 1'b0;
            rsp_corrupt_q <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            param_q       <= param_d;
            size_q        <= size_d;
            source_q      <= source_d;
            address_q     <= address_d;
            mask_q        <= mask_d;
            data_q        <= data_d;
            corrupt_q     <= corrupt_d;
            start_lane_q  <= start_lane_d;
            nbeats_q      <= nbeats_d;
            abeats_q      <= abeats_d;
            acnt_q        <= acnt_d;
            dcnt_q        <= dcnt_d;
            a_started_q   <= a_started_d;
            d_done_q      <= d_done_d;
            rsp_opcode_q  <= rsp_opcode_d;
            rsp_param_q   <= rsp_param_d;
            rsp_sink_q    <= rsp_sink_d;
            rsp_denied_q  <= rsp_denied_d;
            rsp_corrupt_q <= rsp_corrupt_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_tluh_wide_to_narrow_bridge.sv
// Directed bench for the wide-to-narrow TL-UH bridge.
module tb_tluh_wide_to_narrow_bridge;

    logic               clk;
    logic               rst_n;
    tluh_wide::tluh_m2s w_m2s;
    tluh_wide::tluh_s2m w_s2m;
    logic [2:0]   n_a_opcode;
    logic [2:0]   n_a_param;
    logic [2:0]   n_a_size;
    logic [1:0]   n_a_source;
    logic [27:0]  n_a_address;
    logic [3:0]   n_a_mask;
    logic [31:0]  n_a_data;
    logic         n_a_corrupt;
    logic         n_a_valid;
    logic         n_a_ready;
    logic [2:0]   n_d_opcode;
    logic [1:0]   n_d_param;
    logic [2:0]   n_d_size;
    logic [1:0]   n_d_source;
    logic [0:0]   n_d_sink;
    logic         n_d_denied;
    logic [31:0]  n_d_data;
    logic         n_d_corrupt;
    logic         n_d_valid;
    logic         n_d_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    tluh_wide_to_narrow_bridge #(.NDW(32), .NSINKW(1)) dut (
        .tilelink_clock_i  (clk),
        .tilelink_reset_ni (rst_n),
        .w_m2s_i           (w_m2s),
        .w_s2m_o           (w_s2m),
        .n_a_opcode_o      (n_a_opcode),
        .n_a_param_o       (n_a_param),
        .n_a_size_o        (n_a_size),
        .n_a_source_o      (n_a_source),
        .n_a_address_o     (n_a_address),
        .n_a_mask_o        (n_a_mask),
        .n_a_data_o        (n_a_data),
        .n_a_corrupt_o     (n_a_corrupt),
        .n_a_valid_o       (n_a_valid),
        .n_a_ready_i       (n_a_ready),
        .n_d_opcode_i      (n_d_opcode),
        .n_d_param_i       (n_d_param),
        .n_d_size_i        (n_d_size),
        .n_d_source_i      (n_d_source),
        .n_d_sink_i        (n_d_sink),
        .n_d_denied_i      (n_d_denied),
        .n_d_data_i        (n_d_data),
        .n_d_corrupt_i     (n_d_corrupt),
        .n_d_valid_i       (n_d_valid),
        .n_d_ready_o       (n_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                       input logic [27:0] addr, input logic [15:0] mask, input logic [127:0] data);
        w_m2s.a_opcode  = op;
        w_m2s.a_param   = 3'd0;
        w_m2s.a_size    = sz;
        w_m2s.a_source  = src;
        w_m2s.a_address = addr;
        w_m2s.a_mask    = mask;
        w_m2s.a_data    = data;
        w_m2s.a_corrupt = 1'b0;
        w_m2s.a_valid   = 1'b1;
    endtask

    task automatic dbeat(input logic [2:0] op, input logic [31:0] data, input logic denied);
        n_d_opcode  = op;
        n_d_data    = data;
        n_d_denied  = denied;
        n_d_valid   = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        w_m2s       = '0;
        n_a_ready   = 1'b1;
        n_d_opcode  = '0;
        n_d_param   = '0;
        n_d_size    = '0;
        n_d_source  = '0;
        n_d_sink    = '0;
        n_d_denied  = 1'b0;
        n_d_data    = '0;
        n_d_corrupt = 1'b0;
        n_d_valid   = 1'b0;

        // Reset state
        #3;
        chk("rst_a_ready", w_s2m.a_ready, 0);
        chk("rst_n_a_valid", n_a_valid, 0);
        chk("rst_d_valid", w_s2m.d_valid, 0);
        chk("rst_n_d_ready", n_d_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_a_ready", w_s2m.a_ready, 1);

        // 1: Get size=4 @0x100, four AccessAckData beats
        req(3'd4, 3'd4, 2'd2, 28'h100, 16'hFFFF, 128'h0);
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t1_n_a_valid", n_a_valid, 1);
        chk("t1_n_a_opcode", n_a_opcode, 4);
        chk("t1_n_a_address", n_a_address, 28'h100);
        chk("t1_n_a_mask", n_a_mask, 4'hF);
        chk("t1_a_ready_busy", w_s2m.a_ready, 0);
        chk("t1_n_d_ready_pre", n_d_ready, 0);
        tick();
        chk("t1_n_a_valid_done", n_a_valid, 0);
        chk("t1_n_d_ready", n_d_ready, 1);
        dbeat(3'd1, 32'h11111111, 1'b0);
        tick();
        dbeat(3'd1, 32'h22222222, 1'b0);
        tick();
        dbeat(3'd1, 32'h33333333, 1'b0);
        tick();
        chk("t1_d_valid_early", w_s2m.d_valid, 0);
        dbeat(3'd1, 32'h44444444, 1'b0);
        tick();
        n_d_valid = 1'b0;
        chk("t1_d_valid", w_s2m.d_valid, 1);
        chk("t1_d_data", w_s2m.d_data, 128'h44444444_33333333_22222222_11111111);
        chk("t1_d_opcode", w_s2m.d_opcode, 1);
        chk("t1_d_size", w_s2m.d_size, 4);
        chk("t1_d_source", w_s2m.d_source, 2);
        chk("t1_d_denied", w_s2m.d_denied, 0);
        w_m2s.d_ready = 1'b1;
        tick();
        w_m2s.d_ready = 1'b0;
        chk("t1_d_valid_clr", w_s2m.d_valid, 0);
        chk("t1_a_ready_back", w_s2m.a_ready, 1);

        // 2: PutFull size=2 @0x108, lane 2
        req(3'd0, 3'd2, 2'd1, 28'h108, 16'h0F00, {32'h0, 32'hDEADBEEF, 64'h0});
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t2_n_a_valid", n_a_valid, 1);
        chk("t2_n_a_mask", n_a_mask, 4'hF);
        chk("t2_n_a_data", n_a_data, 32'hDEADBEEF);
        chk("t2_n_a_address", n_a_address, 28'h108);
        tick();
        chk("t2_n_a_valid_done", n_a_valid, 0);
        dbeat(3'd0, 32'h0, 1'b0);
        tick();
        n_d_valid = 1'b0;
        chk("t2_d_valid", w_s2m.d_valid, 1);
        chk("t2_d_opcode", w_s2m.d_opcode, 0);
        chk("t2_d_size", w_s2m.d_size, 2);
        w_m2s.d_ready = 1'b1;
        tick();
        w_m2s.d_ready = 1'b0;

        // 3: PutFull size=4 with stalling narrow A ready, early AccessAck
        n_a_ready = 1'b0;
        req(3'd0, 3'd4, 2'd3, 28'h200, 16'hFFFF,
            128'h3D3D3D3D_2C2C2C2C_1B1B1B1B_0A0A0A0A);
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t3_b0_data", n_a_data, 32'h0A0A0A0A);
        tick();
        chk("t3_b0_stall_valid", n_a_valid, 1);
        chk("t3_b0_stall_data", n_a_data, 32'h0A0A0A0A);
        n_a_ready = 1'b1;
        tick();
        chk("t3_b1_data", n_a_data, 32'h1B1B1B1B);
        chk("t3_n_d_ready", n_d_ready, 1);
        n_a_ready = 1'b0;
        dbeat(3'd0, 32'h0, 1'b0);
        tick();
        n_d_valid = 1'b0;
        chk("t3_b1_stall_data", n_a_data, 32'h1B1B1B1B);
        chk("t3_no_early_resp", w_s2m.d_valid, 0);
        chk("t3_addr_stable", n_a_address, 28'h200);
        n_a_ready = 1'b1;
        tick();
        chk("t3_b2_data", n_a_data, 32'h2C2C2C2C);
        n_a_ready = 1'b0;
        tick();
        chk("t3_b2_stall_data", n_a_data, 32'h2C2C2C2C);
        n_a_ready = 1'b1;
        tick();
        chk("t3_b3_data", n_a_data, 32'h3D3D3D3D);
        chk("t3_b3_mask", n_a_mask, 4'hF);
        chk("t3_d_valid_pre", w_s2m.d_valid, 0);
        tick();
        chk("t3_d_valid", w_s2m.d_valid, 1);
        chk("t3_d_opcode", w_s2m.d_opcode, 0);
        chk("t3_n_a_valid_off", n_a_valid, 0);
        chk("t3_d_source", w_s2m.d_source, 3);
        w_m2s.d_ready = 1'b1;
        tick();
        w_m2s.d_ready = 1'b0;

        // 4: Get size=5 is refused without narrow traffic
        req(3'd4, 3'd5, 2'd3, 28'h300, 16'hFFFF, 128'h0);
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t4_n_a_valid", n_a_valid, 0);
        chk("t4_d_valid", w_s2m.d_valid, 1);
        chk("t4_d_opcode", w_s2m.d_opcode, 1);
        chk("t4_d_denied", w_s2m.d_denied, 1);
        chk("t4_d_corrupt", w_s2m.d_corrupt, 1);
        chk("t4_d_data", w_s2m.d_data, 128'h0);
        chk("t4_d_size", w_s2m.d_size, 5);
        w_m2s.d_ready = 1'b1;
        tick();
        w_m2s.d_ready = 1'b0;

        // 5: Get size=3 @0x18, lanes 2/3, denied on beat 2, wide back-pressure
        req(3'd4, 3'd3, 2'd0, 28'h18, 16'hFF00, 128'h0);
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t5_n_a_mask", n_a_mask, 4'hF);
        chk("t5_n_a_size", n_a_size, 3);
        tick();
        dbeat(3'd1, 32'hAAAA0001, 1'b0);
        tick();
        chk("t5_d_valid_early", w_s2m.d_valid, 0);
        dbeat(3'd1, 32'hBBBB0002, 1'b1);
        tick();
        n_d_valid  = 1'b0;
        n_d_denied = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_d_valid_hold", w_s2m.d_valid, 1);
            chk("t5_d_data", w_s2m.d_data, {32'hBBBB0002, 32'hAAAA0001, 64'h0});
            chk("t5_d_denied", w_s2m.d_denied, 1);
            chk("t5_d_corrupt", w_s2m.d_corrupt, 0);
            tick();
        end
        w_m2s.d_ready = 1'b1;
        tick();
        w_m2s.d_ready = 1'b0;
        chk("t5_d_valid_clr", w_s2m.d_valid, 0);

        // 6: reset in the middle of SEND, then a clean Get
        n_a_ready = 1'b0;
        req(3'd4, 3'd4, 2'd1, 28'h100, 16'hFFFF, 128'h0);
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t6_n_a_valid_pre", n_a_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_n_a_valid", n_a_valid, 0);
        chk("t6_rst_a_ready", w_s2m.a_ready, 0);
        chk("t6_rst_d_valid", w_s2m.d_valid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_idle_a_ready", w_s2m.a_ready, 1);
        chk("t6_idle_n_a_valid", n_a_valid, 0);
        n_a_ready = 1'b1;
        req(3'd4, 3'd2, 2'd2, 28'h4, 16'h00F0, 128'h0);
        tick();
        w_m2s.a_valid = 1'b0;
        chk("t6_n_a_address", n_a_address, 28'h4);
        chk("t6_n_a_mask", n_a_mask, 4'hF);
        tick();
        dbeat(3'd1, 32'h5555AAAA, 1'b0);
        tick();
        n_d_valid = 1'b0;
        chk("t6_d_valid", w_s2m.d_valid, 1);
        chk("t6_d_data", w_s2m.d_data, {64'h0, 32'h5555AAAA, 32'h0});
        chk("t6_d_denied", w_s2m.d_denied, 0);
        w_m2s.d_ready = 1'b1;
        tick();
        w_m2s.d_ready = 1'b0;
        chk("t6_d_valid_clr", w_s2m.d_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
